// File: rtl/clk_strobe_gen.sv
// Multi-channel clock-enable strobe and divided-clock generator behind a qualified lock.
// Optional RUN->WAIT_LOCK loss counter on output loss_cnt when CLK_STROBE_GEN_LOSS_CNT_EN is defined.
module clk_strobe_gen #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 1,
    parameter int LOCK_CYCLES = 64,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              lock_in,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] strobe,
    output logic [NUM_CH-1:0] outclk,
`ifdef CLK_STROBE_GEN_LOSS_CNT_EN
    output logic [7:0]        loss_cnt,
`endif
    output logic              locked
);

    localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LK_W-1:0]  LK_LAST = LK_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        ALIGN,
        RUN
    } state_t;

    state_t           state_q;
    logic [LK_W-1:0]  stable_q;
    logic [CNT_W-1:0] shadow_q [NUM_CH];
    logic [CNT_W-1:0] active_q [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [NUM_CH];

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= WAIT_LOCK;
            stable_q <= '0;
            locked   <= 1'b0;
            strobe   <= '0;
            outclk   <= '0;
`ifdef CLK_STROBE_GEN_LOSS_CNT_EN
            loss_cnt <= '0;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= DEF_DIV;
                active_q[i] <= DEF_DIV;
                cnt_q[i]    <= '0;
            end
        end else begin
            // A channel index that matches no loop value is silently dropped.
            for (int i = 0; i < NUM_CH; i++) begin
                if (div_wr && (div_ch == CH_W'(i))) begin
                    shadow_q[i] <= div_val;
                end
            end

            unique case (state_q)
                WAIT_LOCK: begin
                    locked <= 1'b0;
                    strobe <= '0;
                    outclk <= '0;
                    if (!lock_in) begin
                        stable_q <= '0;
                    end else if (stable_q == LK_LAST) begin
                        stable_q <= '0;
                        state_q  <= ALIGN;
                    end else begin
                        stable_q <= stable_q + LK_W'(1);
                    end
                end

                ALIGN: begin
                    strobe <= '0;
                    outclk <= '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        active_q[i] <= shadow_q[i];
                        cnt_q[i]    <= '0;
                    end
                    if (lock_in) begin
                        state_q <= RUN;
                        locked  <= 1'b1;
                    end else begin
                        state_q <= WAIT_LOCK;
                        locked  <= 1'b0;
                    end
                end

                RUN: begin
                    if (!lock_in) begin
                        state_q  <= WAIT_LOCK;
                        stable_q <= '0;
                        locked   <= 1'b0;
                        strobe   <= '0;
                        outclk   <= '0;
`ifdef CLK_STROBE_GEN_LOSS_CNT_EN
                        if (loss_cnt != 8'hFF) begin
                            loss_cnt <= loss_cnt + 8'd1;
                        end
`endif
                        for (int i = 0; i < NUM_CH; i++) begin
                            cnt_q[i] <= '0;
                        end
                    end else begin
                        // Divider swaps only at wrap, so a period is never cut short.
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (cnt_q[i] == active_q[i]) begin
                                cnt_q[i]    <= '0;
                                active_q[i] <= shadow_q[i];
                                strobe[i]   <= 1'b1;
                                outclk[i]   <= ~outclk[i];
                            end else begin
                                cnt_q[i]    <= cnt_q[i] + CNT_W'(1);
                                strobe[i]   <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= WAIT_LOCK;
                    locked  <= 1'b0;
                    strobe  <= '0;
                    outclk  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Directed bench for clk_strobe_gen: vector table for the running channels plus
// hand-written lock, glitch, write-on-wrap and reset sequences.
module tb_clk_strobe_gen;

    localparam int NCH = 3;

    logic            refclk;
    logic            rst;
    logic            lock_in;
    logic            div_wr;
    logic [1:0]      div_ch;
    logic [15:0]     div_val;
    logic [NCH-1:0]  strobe;
    logic [NCH-1:0]  outclk;
    logic            locked;
`ifdef CLK_STROBE_GEN_LOSS_CNT_EN
    logic [7:0]      loss_cnt;
`endif

    int errs   = 0;
    int checks = 0;

    clk_strobe_gen #(
        .NUM_CH(NCH),
        .CNT_W(16),
        .DEFAULT_DIV(1),
        .LOCK_CYCLES(64)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .lock_in(lock_in),
        .div_wr(div_wr),
        .div_ch(div_ch),
        .div_val(div_val),
        .strobe(strobe),
        .outclk(outclk),
`ifdef CLK_STROBE_GEN_LOSS_CNT_EN
        .loss_cnt(loss_cnt),
`endif
        .locked(locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        logic           lk;
        logic           wr;
        logic [1:0]     ch;
        logic [15:0]    val;
        logic [NCH-1:0] s;
        logic [NCH-1:0] o;
        logic           l;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Holds lock_in high for 64 edges (must stay unlocked) then one more (must lock).
    task automatic wait_lock(input string name);
        logic bad;
        bad = 1'b0;
        lock_in = 1'b1;
        for (int e = 1; e <= 64; e++) begin
            tick();
            bad = bad | locked | (|strobe) | (|outclk);
        end
        chk({name, "_prelock"}, 32'(bad), 32'd0);
        tick();
        chk({name, "_locked"}, 32'(locked), 32'd1);
        chk({name, "_strobe_at_lock"}, 32'(strobe), 32'd0);
    endtask

    initial begin
        logic bad;
        logic b1;

        // Rows follow the edge after lock: ch0 D=0, ch1 D=1, ch2 D=3, then lock loss.
        tbl[0] = '{1'b1, 1'b0, 2'd0, 16'd0, 3'b001, 3'b001, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 2'd0, 16'd0, 3'b011, 3'b010, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 2'd0, 16'd0, 3'b001, 3'b011, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 2'd0, 16'd0, 3'b111, 3'b100, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 2'd0, 16'd0, 3'b001, 3'b101, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 2'd0, 16'd0, 3'b011, 3'b110, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 2'd0, 16'd0, 3'b001, 3'b111, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 2'd0, 16'd0, 3'b111, 3'b000, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 2'd1, 16'd3, 3'b000, 3'b000, 1'b0};

        rst     = 1'b1;
        lock_in = 1'b1;
        div_wr  = 1'b0;
        div_ch  = '0;
        div_val = '0;
        tick();
        tick();
        chk("rst_strobe", 32'(strobe), 32'd0);
        chk("rst_outclk", 32'(outclk), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
`ifdef CLK_STROBE_GEN_LOSS_CNT_EN
        chk("rst_loss_cnt", 32'(loss_cnt), 32'd0);
`endif

        // Program dividers while waiting; locked must rise on the 65th edge.
        rst = 1'b0;
        bad = 1'b0;
        for (int e = 1; e <= 64; e++) begin
            div_wr  = (e <= 3);
            div_ch  = 2'(e - 1);
            div_val = (e == 1) ? 16'd0 : (e == 2) ? 16'd1 : 16'd3;
            tick();
            bad = bad | locked | (|strobe) | (|outclk);
        end
        div_wr = 1'b0;
        chk("lockq_prelock", 32'(bad), 32'd0);
        tick();
        chk("lockq_locked", 32'(locked), 32'd1);
        chk("lockq_strobe", 32'(strobe), 32'd0);

        for (int r = 0; r < 10; r++) begin
            lock_in = tbl[r].lk;
            div_wr  = tbl[r].wr;
            div_ch  = tbl[r].ch;
            div_val = tbl[r].val;
            tick();
            chk($sformatf("vec%0d_strobe", r), 32'(strobe), 32'(tbl[r].s));
            chk($sformatf("vec%0d_outclk", r), 32'(outclk), 32'(tbl[r].o));
            chk($sformatf("vec%0d_locked", r), 32'(locked), 32'(tbl[r].l));
        end
        div_wr = 1'b0;
`ifdef CLK_STROBE_GEN_LOSS_CNT_EN
        chk("loss_cnt_first", 32'(loss_cnt), 32'd1);
`endif

        // Glitch at stable count 40 restarts qualification.
        lock_in = 1'b1;
        repeat (40) tick();
        lock_in = 1'b0;
        tick();
        chk("glitch_locked", 32'(locked), 32'd0);
        wait_lock("glitch");

        // ch1 D=3: write D=7 on its wrap edge; write to channel 3 is dropped.
        for (int k = 1; k <= 25; k++) begin
            div_wr  = (k == 2) || (k == 4);
            div_ch  = (k == 2) ? 2'd3 : 2'd1;
            div_val = (k == 2) ? 16'd0 : 16'd7;
            tick();
            b1 = (k == 4) || (k == 8) || (k == 16) || (k == 24);
            chk($sformatf("wrap_k%0d", k), 32'(strobe), 32'({(k % 4) == 0, b1, 1'b1}));
        end
        div_wr = 1'b0;

        // Reset mid-RUN discards the pending D=9 for ch0.
        div_wr  = 1'b1;
        div_ch  = 2'd0;
        div_val = 16'd9;
        tick();
        div_wr = 1'b0;
        rst    = 1'b1;
        tick();
        chk("midrst_strobe", 32'(strobe), 32'd0);
        chk("midrst_outclk", 32'(outclk), 32'd0);
        chk("midrst_locked", 32'(locked), 32'd0);
`ifdef CLK_STROBE_GEN_LOSS_CNT_EN
        chk("midrst_loss_cnt", 32'(loss_cnt), 32'd0);
`endif
        rst = 1'b0;
        wait_lock("relock");
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("dflt_s_k%0d", k), 32'(strobe),
                (k % 2 == 0) ? 32'd7 : 32'd0);
            chk($sformatf("dflt_o_k%0d", k), 32'(outclk),
                (k == 2 || k == 3) ? 32'd7 : 32'd0);
        end

`ifdef CLK_STROBE_GEN_LOSS_CNT_EN
        for (int n = 1; n <= 300; n++) begin
            lock_in = 1'b0;
            tick();
            if (n == 1) chk("loss_cnt_one", 32'(loss_cnt), 32'd1);
            lock_in = 1'b1;
            repeat (65) tick();
        end
        chk("loss_cnt_sat", 32'(loss_cnt), 32'd255);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
